// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 8-bit ALU: arbitrates round-robin and runs
// each 16-bit operation as a low-byte pass followed by a high-byte pass.
module alu_arbiter #(
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic        IN_clk,
    input  logic        IN_rst,
    input  logic [1:0]  IN_req,
    input  logic [3:0]  IN_op0,
    input  logic [3:0]  IN_op1,
    input  logic [15:0] IN_a0,
    input  logic [15:0] IN_b0,
    input  logic [15:0] IN_a1,
    input  logic [15:0] IN_b1,
    input  logic [7:0]  IN_S,
    input  logic        IN_carry_in,
    input  logic        IN_zero,
    output logic [7:0]  OUT_data_a,
    output logic [7:0]  OUT_data_b,
    output logic [3:0]  OUT_ALU_OP,
    output logic        OUT_carry_out,
    output logic [1:0]  OUT_grant,
    output logic        OUT_busy,
    output logic [1:0]  OUT_done,
    output logic [15:0] OUT_result,
    output logic        OUT_neg_ans,
    output logic        OUT_zero,
    output logic        OUT_less_than
);

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_AND = 4'hC;
    localparam logic [3:0] OP_OR  = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;

    state_t      state_reg;
    logic [3:0]  op_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [7:0]  lo_reg;
    logic [7:0]  hi_reg;
    logic        lo_zero_reg;
    logic        hi_zero_reg;
    logic        hi_carry_reg;
    logic        last_reg;

    logic [3:0]  op_in [2];
    logic [15:0] a_in  [2];
    logic [15:0] b_in  [2];
    logic        pick;
    logic [1:0]  grant_next;

    assign op_in[0] = IN_op0;
    assign op_in[1] = IN_op1;
    assign a_in[0]  = IN_a0;
    assign a_in[1]  = IN_a1;
    assign b_in[0]  = IN_b0;
    assign b_in[1]  = IN_b1;

    function automatic logic is_subtract(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // Carry ripples from the low byte into the high byte only for arithmetic ops.
    function automatic logic chains_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic op_valid(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_CMP);
    endfunction

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        pick = 1'b0;
        if (IN_req == 2'b11) begin
            pick = ~last_reg;
        end else begin
            pick = IN_req[1];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_next[gi] = (pick == 1'(gi));
        end
    endgenerate

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= 4'h0;
            a_reg         <= 16'h0000;
            b_reg         <= 16'h0000;
            lo_reg        <= 8'h00;
            hi_reg        <= 8'h00;
            lo_zero_reg   <= 1'b0;
            hi_zero_reg   <= 1'b0;
            hi_carry_reg  <= 1'b0;
            last_reg      <= 1'b1;
            OUT_data_a    <= 8'h00;
            OUT_data_b    <= 8'h00;
            OUT_ALU_OP    <= 4'h0;
            OUT_carry_out <= 1'b0;
            OUT_grant     <= 2'b00;
            OUT_busy      <= 1'b0;
            OUT_done      <= 2'b00;
            OUT_result    <= 16'h0000;
            OUT_neg_ans   <= 1'b0;
            OUT_zero      <= 1'b0;
            OUT_less_than <= 1'b0;
        end else begin
            OUT_done <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (|IN_req) begin
                        state_reg     <= ST_LO;
                        OUT_grant     <= grant_next;
                        OUT_busy      <= 1'b1;
                        last_reg      <= pick;
                        op_reg        <= op_in[pick];
                        a_reg         <= a_in[pick];
                        b_reg         <= b_in[pick];
                        OUT_data_a    <= a_in[pick][7:0];
                        OUT_data_b    <= b_in[pick][7:0];
                        OUT_ALU_OP    <= op_in[pick];
                        // Subtraction is a + ~b + 1, so the low byte starts with carry set.
                        OUT_carry_out <= is_subtract(op_in[pick]);
                    end
                end
                ST_LO: begin
                    state_reg     <= ST_HI;
                    lo_reg        <= IN_S;
                    lo_zero_reg   <= IN_zero;
                    OUT_data_a    <= a_reg[15:8];
                    OUT_data_b    <= b_reg[15:8];
                    OUT_carry_out <= chains_carry(op_reg) & IN_carry_in;
                end
                ST_HI: begin
                    state_reg    <= ST_DONE;
                    hi_reg       <= IN_S;
                    hi_zero_reg  <= IN_zero;
                    hi_carry_reg <= IN_carry_in;
                    if (IDLE_ZERO) begin
                        OUT_data_a    <= 8'h00;
                        OUT_data_b    <= 8'h00;
                        OUT_ALU_OP    <= 4'h0;
                        OUT_carry_out <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    OUT_grant <= 2'b00;
                    OUT_busy  <= 1'b0;
                    OUT_done  <= OUT_grant;
                    if (op_valid(op_reg)) begin
                        OUT_result    <= {hi_reg, lo_reg};
                        OUT_zero      <= lo_zero_reg & hi_zero_reg;
                        OUT_neg_ans   <= is_subtract(op_reg) & hi_reg[7];
                        // The final carry of a compare is "no borrow"; its inverse means a < b.
                        OUT_less_than <= (op_reg == OP_CMP) & ~hi_carry_reg;
                    end else begin
                        OUT_result    <= 16'h0000;
                        OUT_zero      <= 1'b1;
                        OUT_neg_ans   <= 1'b0;
                        OUT_less_than <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU closing the loop.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [3:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic [7:0]  alu_s;
    logic        alu_c, alu_z;
    logic [7:0]  data_a, data_b;
    logic [3:0]  alu_op;
    logic        carry_out;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  done;
    logic [15:0] result;
    logic        neg_ans, zero, less_than;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .IN_clk        (clk),
        .IN_rst        (rst),
        .IN_req        (req),
        .IN_op0        (op0),
        .IN_op1        (op1),
        .IN_a0         (a0),
        .IN_b0         (b0),
        .IN_a1         (a1),
        .IN_b1         (b1),
        .IN_S          (alu_s),
        .IN_carry_in   (alu_c),
        .IN_zero       (alu_z),
        .OUT_data_a    (data_a),
        .OUT_data_b    (data_b),
        .OUT_ALU_OP    (alu_op),
        .OUT_carry_out (carry_out),
        .OUT_grant     (grant),
        .OUT_busy      (busy),
        .OUT_done      (done),
        .OUT_result    (result),
        .OUT_neg_ans   (neg_ans),
        .OUT_zero      (zero),
        .OUT_less_than (less_than)
    );

    // Shared ALU: add, subtract/compare as a + ~b + cin, and, or.
    always_comb begin
        logic [8:0] sum;
        sum   = 9'h000;
        alu_s = 8'h00;
        alu_c = 1'b0;
        case (alu_op)
            4'hA:       sum = {1'b0, data_a} + {1'b0, data_b} + 9'(carry_out);
            4'hB, 4'hE: sum = {1'b0, data_a} + {1'b0, ~data_b} + 9'(carry_out);
            4'hC:       sum = {1'b0, data_a & data_b};
            4'hD:       sum = {1'b0, data_a | data_b};
            default:    sum = 9'h000;
        endcase
        alu_s = sum[7:0];
        alu_c = sum[8];
        alu_z = (alu_s == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input int who, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_neg,
                          input logic exp_zero, input logic exp_lt, input logic exp_hi_cin);
        logic [1:0] g;
        g = (who == 0) ? 2'b01 : 2'b10;
        if (who == 0) begin
            op0 = op; a0 = a; b0 = b; req = 2'b01;
        end else begin
            op1 = op; a1 = a; b1 = b; req = 2'b10;
        end
        step();
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " lo_a"}, 32'(data_a), 32'(a[7:0]));
        chk({tag, " lo_b"}, 32'(data_b), 32'(b[7:0]));
        chk({tag, " lo_op"}, 32'(alu_op), 32'(op));
        chk({tag, " lo_cout"}, 32'(carry_out), 32'((op == 4'hB) || (op == 4'hE)));
        // Drop the request and disturb the operands; the latched operation must be unaffected.
        req = 2'b00;
        op0 = 4'h0; a0 = ~a; b0 = ~b;
        op1 = 4'h0; a1 = ~a; b1 = ~b;
        step();
        chk({tag, " hi_a"}, 32'(data_a), 32'(a[15:8]));
        chk({tag, " hi_b"}, 32'(data_b), 32'(b[15:8]));
        chk({tag, " hi_cout"}, 32'(carry_out), 32'(exp_hi_cin));
        step();
        chk({tag, " done_early"}, 32'(done), 32'd0);
        chk({tag, " idle_a"}, 32'(data_a), 32'd0);
        step();
        chk({tag, " done"}, 32'(done), 32'(g));
        chk({tag, " result"}, 32'(result), 32'(exp_res));
        chk({tag, " neg"}, 32'(neg_ans), 32'(exp_neg));
        chk({tag, " zero"}, 32'(zero), 32'(exp_zero));
        chk({tag, " lt"}, 32'(less_than), 32'(exp_lt));
        chk({tag, " grant_clr"}, 32'(grant), 32'd0);
        chk({tag, " busy_clr"}, 32'(busy), 32'd0);
        step();
        chk({tag, " done_once"}, 32'(done), 32'd0);
        chk({tag, " result_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        logic [1:0] eg;
        rst = 1'b1; req = 2'b00;
        op0 = 4'h0; op1 = 4'h0;
        a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
        repeat (3) step();
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst data_a", 32'(data_a), 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'd0);
        chk("rst flags", 32'({neg_ans, zero, less_than, carry_out}), 32'd0);
        rst = 1'b0;
        step();

        run_op("add",  0, 4'hA, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("add r0 00FF+0001 -> result %h zero %b", result, zero);
        run_op("sub",  1, 4'hB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("sub r1 0003-0005 -> result %h neg %b", result, neg_ans);
        run_op("cmplt", 0, 4'hE, 16'h0005, 16'h0009, 16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b0);
        $display("cmp r0 0005?0009 -> lt %b neg %b", less_than, neg_ans);
        run_op("cmpeq", 1, 4'hE, 16'h0009, 16'h0009, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        $display("cmp r1 0009?0009 -> lt %b zero %b", less_than, zero);
        run_op("and",  0, 4'hC, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("and r0 0F0F&00FF -> result %h", result);
        run_op("or",   1, 4'hD, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("or  r1 1200|0034 -> result %h", result);
        run_op("badop", 0, 4'h3, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        $display("op3 r0 -> result %h zero %b", result, zero);

        // Continuous tie after reset: grants alternate starting with requester 0, 4 cycles apart.
        rst = 1'b1; step(); rst = 1'b0;
        op0 = 4'hA; a0 = 16'h0001; b0 = 16'h0001;
        op1 = 4'hD; a1 = 16'h0010; b1 = 16'h0001;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            step();
            chk($sformatf("rr grant%0d", k), 32'(grant), 32'(eg));
            step();
            chk($sformatf("rr hold%0d", k), 32'(grant), 32'(eg));
            step();
            step();
            chk($sformatf("rr gap%0d", k), 32'(grant), 32'd0);
            chk($sformatf("rr done%0d", k), 32'(done), 32'(eg));
            $display("tie round %0d -> grant %b done %b", k, eg, done);
        end
        req = 2'b00;
        repeat (4) step();

        // Reset during HI: no done pulse, outputs cleared, pointer back to requester 0.
        op0 = 4'hA; a0 = 16'h0102; b0 = 16'h0304; req = 2'b01;
        step();
        req = 2'b00;
        step();
        chk("rstmid in_hi", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid grant", 32'(grant), 32'd0);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid done", 32'(done), 32'd0);
        chk("rstmid result", 32'(result), 32'd0);
        chk("rstmid alu", 32'({data_a, data_b, alu_op, carry_out}), 32'd0);
        chk("rstmid flags", 32'({neg_ans, zero, less_than}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rstmid nodone%0d", k), 32'(done), 32'd0);
        end
        req = 2'b11;
        step();
        chk("rstmid tie", 32'(grant), 32'd1);
        $display("reset in HI -> next tie grant %b", grant);
        req = 2'b00;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
